oled_init_seq: RTL and testbench

- Power-up and initialisation sequencer for the SSD1306-class OLED panel. Sits directly upstream of the SPI interface block.
- Walks a fixed command script and issues command bytes over an AXI4-stream master.
- Drives the panel's D/C, RES#, VDD and VBAT control pins and inserts millisecond delays.
- Asserts doneOut when the panel is ready for the pixel-data stage.

---
 rtl/oled_init_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_oled_init_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_init_seq.sv
// oled_init_seq
// Power-up and initialisation sequencer for an SSD1306-class OLED panel.
// It walks a fixed command script and issues command bytes on an AXI4-stream
// master toward the SPI interface block. It also drives the RES#, VDD and
// VBAT pins and inserts millisecond delays. doneOut is raised when the panel
// is ready for pixel data.
//
// Build option: define OLED_DISPLAY_TEST_EN to append 0xA5 (entire display on)
// before END, so every pixel lights after init.
//
// Script entry format: [15:14] opcode, [13:0] argument
//   00 SEND  : emit byte arg[7:0]
//   01 DELAY : wait arg ms (0 behaves as 1 ms)
//   10 PIN   : arg[2:0] = {vbatN, vddN, resN}
//   11 END   : finish
module oled_init_seq #(
    parameter int MS_CYCLES    = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       startIn,
    output logic       busyOut,
    output logic       doneOut,
    output logic       mAxiSTvalid,
    output logic [7:0] mAxiSTdata,
    input  logic       mAxiSTready,
    output logic       dcOut,
    output logic       resNOut,
    output logic       vddNOut,
    output logic       vbatNOut
);

    localparam int CYC_W = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam int GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MS_CYCLES - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYCLES - 1);

    localparam logic [1:0] OP_SEND  = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_PIN   = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_PIN,
        S_SEND_WAIT,
        S_SEND,
        S_GUARD,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_DELAY,
        S_DONE
    } stateT;

    // Command script ROM. PIN arguments are {vbatN, vddN, resN}.
    function automatic logic [15:0] scriptWord(input logic [4:0] addr);
        logic [15:0] word;
        case (addr)
            5'd0:  word = {OP_PIN,   14'b101};     // VDD on
            5'd1:  word = {OP_DELAY, 14'd1};
            5'd2:  word = {OP_SEND,  14'h00AE};    // display off
            5'd3:  word = {OP_PIN,   14'b100};     // RES# low
            5'd4:  word = {OP_DELAY, 14'd1};
            5'd5:  word = {OP_PIN,   14'b101};     // RES# high
            5'd6:  word = {OP_DELAY, 14'd1};
            5'd7:  word = {OP_SEND,  14'h008D};    // charge pump
            5'd8:  word = {OP_SEND,  14'h0014};
            5'd9:  word = {OP_SEND,  14'h00D9};    // pre-charge period
            5'd10: word = {OP_SEND,  14'h00F1};
            5'd11: word = {OP_PIN,   14'b001};     // VBAT on
            5'd12: word = {OP_DELAY, 14'd100};
            5'd13: word = {OP_SEND,  14'h0081};    // contrast
            5'd14: word = {OP_SEND,  14'h000F};
            5'd15: word = {OP_SEND,  14'h00A0};    // segment remap
            5'd16: word = {OP_SEND,  14'h00C0};    // COM scan direction
            5'd17: word = {OP_SEND,  14'h00DA};    // COM pin config
            5'd18: word = {OP_SEND,  14'h0000};
            5'd19: word = {OP_SEND,  14'h00AF};    // display on
`ifdef OLED_DISPLAY_TEST_EN
            5'd20: word = {OP_SEND,  14'h00A5};    // entire display on
            5'd21: word = {OP_END,   14'd0};
`else
            5'd20: word = {OP_END,   14'd0};
`endif
            default: word = {OP_END, 14'd0};
        endcase
        return word;
    endfunction

    stateT             stateReg, stateNext;
    logic [4:0]        ptrReg, ptrNext;
    logic [15:0]       entryReg;
    logic [CYC_W-1:0]  cycCntReg;
    logic [6:0]        msCntReg;
    logic [GRD_W-1:0]  grdCntReg;
    logic [2:0]        pinsReg;
    logic [6:0]        msLast;
    logic              delayDone;

    // Last ms index for the current DELAY entry; an argument of 0 acts as 1 ms.
    assign msLast    = 7'((entryReg[13:0] == 14'd0) ? 14'd0 : entryReg[13:0] - 14'd1);
    assign delayDone = (cycCntReg == CYC_LAST) && (msCntReg == msLast);

    // State register.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            stateReg <= S_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and next-pointer logic.
    always_comb begin
        stateNext = stateReg;
        ptrNext   = ptrReg;
        case (stateReg)
            S_IDLE, S_DONE: begin
                if (startIn) begin
                    stateNext = S_FETCH;
                    ptrNext   = 5'd0;
                end
            end
            S_FETCH: begin
                case (entryReg[15:14])
                    OP_SEND:  stateNext = S_SEND_WAIT;
                    OP_DELAY: stateNext = S_DELAY;
                    OP_PIN:   stateNext = S_PIN;
                    default:  stateNext = S_DONE;
                endcase
            end
            S_PIN: begin
                stateNext = S_FETCH;
                ptrNext   = ptrReg + 5'd1;
            end
            S_SEND_WAIT: begin
                if (mAxiSTready) begin
                    stateNext = S_SEND;
                end
            end
            S_SEND: begin
                stateNext = S_GUARD;
            end
            S_GUARD: begin
                if (grdCntReg == GRD_LAST) begin
                    stateNext = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                // Downstream must visibly take the byte before the next one.
                if (!mAxiSTready) begin
                    stateNext = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (mAxiSTready) begin
                    stateNext = S_FETCH;
                    ptrNext   = ptrReg + 5'd1;
                end
            end
            S_DELAY: begin
                if (delayDone) begin
                    stateNext = S_FETCH;
                    ptrNext   = ptrReg + 5'd1;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    // Datapath. The ROM read is addressed by the next pointer, so the entry is
    // registered on the edge into FETCH and stays stable while it executes.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            ptrReg    <= 5'd0;
            entryReg  <= 16'd0;
            cycCntReg <= '0;
            msCntReg  <= 7'd0;
            grdCntReg <= '0;
            pinsReg   <= 3'b111;
        end else begin
            ptrReg   <= ptrNext;
            entryReg <= scriptWord(ptrNext);

            if (stateReg == S_DELAY) begin
                if (cycCntReg == CYC_LAST) begin
                    cycCntReg <= '0;
                    msCntReg  <= (msCntReg == msLast) ? 7'd0 : msCntReg + 7'd1;
                end else begin
                    cycCntReg <= cycCntReg + CYC_W'(1);
                end
            end else begin
                cycCntReg <= '0;
                msCntReg  <= 7'd0;
            end

            if (stateReg == S_GUARD) begin
                grdCntReg <= grdCntReg + GRD_W'(1);
            end else begin
                grdCntReg <= '0;
            end

            // Pins are not touched on restart; the script's PIN entries set them.
            if (stateReg == S_PIN) begin
                pinsReg <= entryReg[2:0];
            end
        end
    end

    // Outputs decoded from the registered state and pins.
    always_comb begin
        mAxiSTvalid = (stateReg == S_SEND);
        mAxiSTdata  = (stateReg == S_SEND) ? entryReg[7:0] : 8'h00;
        busyOut     = (stateReg != S_IDLE) && (stateReg != S_DONE);
        doneOut     = (stateReg == S_DONE);
        dcOut       = 1'b0;
        resNOut     = pinsReg[0];
        vddNOut     = pinsReg[1];
        vbatNOut    = pinsReg[2];
    end

endmodule

// File: tb/tb_oled_init_seq.sv
// tb_oled_init_seq
// Scoreboard bench for oled_init_seq with MS_CYCLES=10. The reference model is
// the script's byte list plus timing windows derived from the delay lengths.
// A downstream model captures each byte and stays busy for busyLen cycles.
// Honours OLED_DISPLAY_TEST_EN in the reference byte list.
module tb_oled_init_seq;

    localparam int MS         = 10;
    localparam int GUARD      = 2;
    localparam int RUN_BUDGET = 6000;

    logic       clkIn   = 1'b0;
    logic       rstIn   = 1'b1;
    logic       startIn = 1'b0;
    logic       busyOut;
    logic       doneOut;
    logic       mAxiSTvalid;
    logic [7:0] mAxiSTdata;
    logic       mAxiSTready;
    logic       dcOut;
    logic       resNOut;
    logic       vddNOut;
    logic       vbatNOut;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic holdLow = 1'b0;
    int   busyLen = 20;
    int   busyCnt = 0;

    logic [7:0] refBytes[$];
    logic [7:0] expQ[$];
    logic [7:0] expByte;

    logic prevValid = 1'b0;
    logic prevVddN  = 1'b1;
    logic prevResN  = 1'b1;
    logic prevVbatN = 1'b1;
    int   validCount = 0;
    int   runBytes   = 0;
    logic [7:0] lastByte = 8'h00;
    int   vddFall = -1, resFall = -1, resRise = -1, vbatFall = -1;
    int   aeCycle = -1, f1Cycle = -1, c81Cycle = -1;
    logic armFirst = 1'b0;
    int   firstValid = -1;
    int   releaseCycle = 0;

    oled_init_seq #(
        .MS_CYCLES    (MS),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clkIn       (clkIn),
        .rstIn       (rstIn),
        .startIn     (startIn),
        .busyOut     (busyOut),
        .doneOut     (doneOut),
        .mAxiSTvalid (mAxiSTvalid),
        .mAxiSTdata  (mAxiSTdata),
        .mAxiSTready (mAxiSTready),
        .dcOut       (dcOut),
        .resNOut     (resNOut),
        .vddNOut     (vddNOut),
        .vbatNOut    (vbatNOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Downstream SPI model: takes a byte when idle, then busy for busyLen cycles.
    always @(posedge clkIn) begin
        cycle <= cycle + 1;
        if (rstIn) begin
            busyCnt <= 0;
        end else if (mAxiSTvalid && busyCnt == 0) begin
            busyCnt <= busyLen;
        end else if (busyCnt > 0) begin
            busyCnt <= busyCnt - 1;
        end
    end

    assign mAxiSTready = (busyCnt == 0) && !mAxiSTvalid && !holdLow;

    // Monitor: pops the scoreboard on every byte and logs pin edges.
    always @(negedge clkIn) begin
        if (mAxiSTvalid) begin
            validCount++;
            runBytes++;
            lastByte = mAxiSTdata;
            check("tvalid_single_cycle", int'(prevValid), 0);
            check("dc_is_command", int'(dcOut), 0);
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL byte_order: got %02h expected none", mAxiSTdata);
            end else begin
                expByte = expQ.pop_front();
                check("byte_order", int'(mAxiSTdata), int'(expByte));
                $display("byte %02h at cycle %0d", mAxiSTdata, cycle);
            end
            if (armFirst) begin
                firstValid = cycle;
                armFirst   = 1'b0;
            end
            if (mAxiSTdata == 8'hAE && aeCycle < 0) aeCycle = cycle;
            if (mAxiSTdata == 8'hF1 && f1Cycle < 0) f1Cycle = cycle;
            if (mAxiSTdata == 8'h81 && c81Cycle < 0) c81Cycle = cycle;
        end
        if (prevVddN && !vddNOut && vddFall < 0) vddFall = cycle;
        if (prevResN && !resNOut && resFall < 0) resFall = cycle;
        if (!prevResN && resNOut && resFall >= 0 && resRise < 0) resRise = cycle;
        if (prevVbatN && !vbatNOut && vbatFall < 0) vbatFall = cycle;
        prevValid = mAxiSTvalid;
        prevVddN  = vddNOut;
        prevResN  = resNOut;
        prevVbatN = vbatNOut;
    end

    task automatic startRun(input string tag);
        @(negedge clkIn);
        startIn = 1'b1;
        foreach (refBytes[i]) expQ.push_back(refBytes[i]);
        runBytes = 0;
        @(negedge clkIn);
        startIn = 1'b0;
        check({tag, "_busy_on_accept"}, int'(busyOut), 1);
        check({tag, "_done_cleared"}, int'(doneOut), 0);
        $display("%s: start accepted at cycle %0d", tag, cycle);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!doneOut && n < RUN_BUDGET) begin
            @(negedge clkIn);
            n++;
        end
        check({tag, "_done_reached"}, int'(doneOut), 1);
        check({tag, "_busy_low"}, int'(busyOut), 0);
        check({tag, "_all_bytes_seen"}, expQ.size(), 0);
        check({tag, "_byte_count"}, runBytes, refBytes.size());
        check({tag, "_last_byte"}, int'(lastByte), int'(refBytes[refBytes.size()-1]));
        $display("%s: done at cycle %0d, %0d bytes", tag, cycle, runBytes);
    endtask

    initial begin
        int n;
        int base;

        refBytes = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F,
                     8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
`ifdef OLED_DISPLAY_TEST_EN
        refBytes.push_back(8'hA5);
`endif

        // Reset values
        repeat (3) @(negedge clkIn);
        check("rst_tvalid", int'(mAxiSTvalid), 0);
        check("rst_tdata", int'(mAxiSTdata), 0);
        check("rst_dc", int'(dcOut), 0);
        check("rst_resN", int'(resNOut), 1);
        check("rst_vddN", int'(vddNOut), 1);
        check("rst_vbatN", int'(vbatNOut), 1);
        check("rst_busy", int'(busyOut), 0);
        check("rst_done", int'(doneOut), 0);
        rstIn = 1'b0;

        // Run 1: full sequence from reset with pin timing
        busyLen = 20;
        repeat ($urandom_range(1, 20)) @(negedge clkIn);
        startRun("run1");
        waitDone("run1");
        check("vdd_before_ae", int'(vddFall >= 0 && vddFall < aeCycle), 1);
        checkRange("ae_after_vdd", aeCycle - vddFall, MS + 1, MS + 6);
        checkRange("resN_low_width", resRise - resFall, MS + 1, MS + 6);
        check("vbat_after_f1", int'(vbatFall > f1Cycle && f1Cycle >= 0), 1);
        checkRange("gap_vbat_to_81", c81Cycle - vbatFall, 100 * MS, 100 * MS + 10);
        check("final_resN", int'(resNOut), 1);
        check("final_vddN", int'(vddNOut), 0);
        check("final_vbatN", int'(vbatNOut), 0);

        // Run 2: downstream holds tready low for 500 cycles
        busyLen = $urandom_range(5, 30);
        holdLow = 1'b1;
        startRun("run2");
        base = validCount;
        repeat (500) @(negedge clkIn);
        check("no_valid_while_held", validCount - base, 0);
        check("busy_while_stalled", int'(busyOut), 1);
        holdLow      = 1'b0;
        releaseCycle = cycle;
        armFirst     = 1'b1;
        waitDone("run2");
        check("resume_after_ready", firstValid, releaseCycle + 1);

        // Run 3: reset during the 100 ms delay, then a fresh run
        busyLen = $urandom_range(5, 30);
        startRun("run3a");
        n = 0;
        while (runBytes < 5 && n < RUN_BUDGET) begin
            @(negedge clkIn);
            n++;
        end
        check("run3a_reached_f1", runBytes, 5);
        repeat ($urandom_range(100, 600)) @(negedge clkIn);
        check("run3a_vbat_on_in_delay", int'(vbatNOut), 0);
        rstIn = 1'b1;
        @(negedge clkIn);
        check("midrst_vbatN", int'(vbatNOut), 1);
        check("midrst_vddN", int'(vddNOut), 1);
        check("midrst_resN", int'(resNOut), 1);
        check("midrst_busy", int'(busyOut), 0);
        check("midrst_done", int'(doneOut), 0);
        check("midrst_tvalid", int'(mAxiSTvalid), 0);
        rstIn = 1'b0;
        expQ.delete();
        busyLen = $urandom_range(5, 30);
        startRun("run3b");
        waitDone("run3b");

        // Run 4: start while busy is ignored; start after done replays
        busyLen = $urandom_range(5, 30);
        startRun("run4a");
        repeat ($urandom_range(50, 900)) @(negedge clkIn);
        startIn = 1'b1;
        @(negedge clkIn);
        startIn = 1'b0;
        check("run4a_busy_after_extra_start", int'(busyOut), 1);
        waitDone("run4a");
        repeat ($urandom_range(1, 30)) @(negedge clkIn);
        check("run4b_done_held", int'(doneOut), 1);
        busyLen = $urandom_range(5, 30);
        startRun("run4b");
        waitDone("run4b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog in case a wait misbehaves.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
